// File: rtl/multi_phase_generator.sv
// multi_phase_generator: time-multiplexed multi-channel phase accumulator (NCO core)
// sharing one adder across all channels, one channel per clock per sample tick.
module multi_phase_generator #(
   parameter int NUM_CHANNELS = 4,
   parameter int PHASE_WIDTH  = 32,
   parameter int CH_WIDTH     = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_tick,
   input  logic                   i_delta_wr,
   input  logic [CH_WIDTH-1:0]    i_delta_ch,
   input  logic [PHASE_WIDTH-1:0] i_delta,
   input  logic                   i_phase_clr,
   input  logic [CH_WIDTH-1:0]    i_clr_ch,
   output logic                   o_busy,
   output logic                   o_valid,
   output logic [CH_WIDTH-1:0]    o_ch,
   output logic [PHASE_WIDTH-1:0] o_phase,
   output logic                   o_wrap,
   output logic                   o_overrun
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t                 r_state, w_state_nxt;
   logic [CH_WIDTH-1:0]    r_cnt, w_ch;
   logic                   w_upd, w_last, w_carry;
   logic [PHASE_WIDTH-1:0] r_phase [NUM_CHANNELS];
   logic [PHASE_WIDTH-1:0] r_delta [NUM_CHANNELS];
   logic [PHASE_WIDTH-1:0] w_ph_sel, w_dl_sel, w_sum;
   logic                   r_valid, r_wrap, r_overrun;
   logic [CH_WIDTH-1:0]    r_ch;
   logic [PHASE_WIDTH-1:0] r_out;

   // Channel 0 is computed in the tick cycle itself; RUN covers channels 1..N-1.
   always_comb begin
      w_upd       = (r_state == IDLE && i_tick) || r_state == RUN;
      w_ch        = r_state == RUN ? r_cnt : '0;
      w_last      = w_ch == CH_WIDTH'(NUM_CHANNELS - 1);
      w_state_nxt = (w_upd && !w_last) ? RUN : IDLE;
      w_ph_sel    = '0;
      w_dl_sel    = '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         w_ph_sel = w_ch == CH_WIDTH'(k) ? r_phase[k] : w_ph_sel;
         w_dl_sel = w_ch == CH_WIDTH'(k) ? r_delta[k] : w_dl_sel;
      end
      {w_carry, w_sum} = {1'b0, w_ph_sel} + {1'b0, w_dl_sel};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_ch + 1'b1;
      end
   end

   // Clear takes priority over a same-cycle update of the same channel.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            r_phase[k] <= '0;
            r_delta[k] <= '0;
         end
         r_valid   <= 1'b0;
         r_wrap    <= 1'b0;
         r_overrun <= 1'b0;
         r_ch      <= '0;
         r_out     <= '0;
      end else begin
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (i_phase_clr && i_clr_ch == CH_WIDTH'(k))
               r_phase[k] <= '0;
            else if (w_upd && w_ch == CH_WIDTH'(k))
               r_phase[k] <= w_sum;
            if (i_delta_wr && i_delta_ch == CH_WIDTH'(k))
               r_delta[k] <= i_delta;
         end
         r_valid   <= w_upd;
         r_wrap    <= w_upd && w_carry;
         r_overrun <= i_tick && r_state == RUN;
         if (w_upd) begin
            r_ch  <= w_ch;
            r_out <= w_sum;
         end
      end
   end

   assign o_busy    = r_state == RUN;
   assign o_valid   = r_valid;
   assign o_ch      = r_ch;
   assign o_phase   = r_out;
   assign o_wrap    = r_wrap;
   assign o_overrun = r_overrun;
endmodule

// File: doc/multi_phase_generator.md
Name: multi_phase_generator

Overview:
- Time-multiplexed, multi-channel phase accumulator (NCO core) feeding per-voice waveform/table stages in the audio path.
- One shared adder updates NUM_CHANNELS phase registers, one channel per clock, per sample tick.
- Streams (channel, phase, wrap) results downstream.
- Adds per-channel delta writes, per-channel phase clear (hard sync), busy/overrun reporting.

Parameters:
NUM_CHANNELS  4   number of phase channels, >= 1
PHASE_WIDTH   32  phase and delta width in bits
CH_WIDTH      2   channel index width, >= max(1, clog2(NUM_CHANNELS))

Ports:
i_clk         input   1            system clock
i_rst         input   1            asynchronous, active-high reset
i_tick        input   1            sample tick; starts one sweep over all channels
i_delta_wr    input   1            write strobe for per-channel phase delta
i_delta_ch    input   CH_WIDTH     channel addressed by i_delta_wr
i_delta       input   PHASE_WIDTH  new phase increment
i_phase_clr   input   1            clear strobe for one channel's phase
i_clr_ch      input   CH_WIDTH     channel addressed by i_phase_clr
o_busy        output  1            sweep in progress; i_tick not accepted
o_valid       output  1            o_ch/o_phase/o_wrap valid this cycle
o_ch          output  CH_WIDTH     channel of current result
o_phase       output  PHASE_WIDTH  updated phase of o_ch
o_wrap        output  1            carry out of the update (phase wrapped)
o_overrun     output  1            one-cycle pulse: i_tick rejected while busy

Behaviour:
- Reset (async assert, released synchronously to i_clk):
  - All phase and delta registers 0; FSM IDLE.
  - o_busy, o_valid, o_wrap, o_overrun = 0; o_ch = 0; o_phase = 0.
  - Reset mid-sweep aborts the sweep; remaining channels are not updated.
- FSM states: IDLE, RUN.
  - IDLE: i_tick=1 in cycle t is accepted.
  - Channel k result is registered and presented in cycle t+1+k, k = 0..N-1.
  - o_valid is high in cycles t+1 .. t+N, low otherwise; o_ch = k.
  - o_busy is high in cycles t+1 .. t+N-1; for NUM_CHANNELS=1, o_busy is never high.
  - i_tick in cycle t+N (last result cycle) is accepted, giving back-to-back sweeps every N cycles.
  - i_tick while o_busy=1: ignored; o_overrun=1 in the next cycle; current sweep continues unaffected.
- Update arithmetic: {wrap, phase[k]} <= phase[k] + delta[k] at PHASE_WIDTH+1 bits, modulo 2^PHASE_WIDTH.
  - o_phase is the new value; o_wrap is the carry.
  - delta = 0 gives constant phase, wrap = 0.
- Delta write:
  - i_delta_wr in cycle c updates delta[i_delta_ch] at the end of cycle c.
  - An update computed in cycle c uses the old delta; updates from cycle c+1 onward use the new one.
  - Writes are accepted in any state.
- Phase clear:
  - i_phase_clr in cycle c sets phase[i_clr_ch] = 0 at the end of cycle c.
  - If the same channel is being updated in cycle c, clear wins: stored phase = 0. The presented result is still the computed sum (o_phase, o_wrap).
  - Delta is unaffected.
- Out-of-range index (>= NUM_CHANNELS) on i_delta_ch or i_clr_ch: the write or clear is ignored, no side effects.
- Simultaneous delta write and clear to the same channel: both take effect.
- Outputs hold their last values when o_valid=0, except o_wrap and o_overrun, which are 0 whenever o_valid or the pulse condition is not met.
- Implementation: a single shared adder; the channel counter selects the operands.

Test Plan:
- Reset release, then delta[0]=0x4000_0000 and deltas 1..3 = 0, then 4 ticks spaced 4 cycles apart -> ch0 o_phase = 0x4000_0000, 0x8000_0000, 0xC000_0000, 0x0000_0000, with o_wrap=1 only on the 4th; ch1..3 o_phase = 0 with o_wrap = 0.
- Tick in cycle t -> o_valid in t+1..t+4 with o_ch = 0,1,2,3; o_busy in t+1..t+3. A second tick at t+2 -> o_overrun=1 at t+3, no extra results. A tick at t+4 -> next sweep results at t+5..t+8.
- Sweep in progress, delta write to ch2 = 0x10 in the cycle ch2 is updated -> that result uses the old delta; the next sweep adds 0x10.
- Clear of ch1 in the cycle ch1 is updated (old phase 0x100, delta 0x1) -> presented o_phase = 0x101; next sweep o_phase = 0x1.
- i_rst asserted mid-sweep after ch1's result -> outputs 0 immediately, o_valid=0, all phases read 0 on the next sweep. Writes with i_delta_ch=5 (CH_WIDTH=3, N=4) -> no channel changes.
